// File: rtl/lm07_sensor_emulator.sv
// LM07-style 3-wire SPI temperature sensor responder: shifts a host-supplied word out on SIO.
// Optional macro SIO_TRISTATE_EN: SIO floats (1'bz) whenever sio_oe is low.
module lm07_sensor_emulator #(
    parameter int unsigned       WORD_W      = 16,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] RESET_WORD  = WORD_W'(16'h0C80)
) (
    input  logic              SYSCLK,
    input  logic              RSTN,
    input  logic              CS,
    input  logic              SCK,
    input  logic [WORD_W-1:0] temp_in,
    input  logic              temp_valid,
    output logic              SIO,
    output logic              sio_oe,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic               cs_d;
    logic               sck_d;
    logic               cs_s;
    logic               sck_s;
    logic               cs_fall;
    logic               cs_rise;
    logic               sck_fall;
    logic [WORD_W-1:0]  shadow;
    logic [WORD_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sio_q;

    // Oversampling synchronizers; idle levels are CS high and SCK low.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_d     <= 1'b1;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;

    // Shadow only feeds LOAD, so a mid-frame update lands on the next frame.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            shadow <= RESET_WORD;
        end else if (temp_valid) begin
            shadow <= temp_in;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            sio_q      <= 1'b0;
            sio_oe     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && cs_rise) begin
                // CS released early or after the frame: abort wins over any SCK edge
                state  <= IDLE;
                sio_q  <= 1'b0;
                sio_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sio_q  <= 1'b0;
                        sio_oe <= 1'b0;
                        busy   <= 1'b0;
                        if (cs_fall) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        shreg   <= shadow;
                        sio_q   <= shadow[WORD_W-1];
                        bit_cnt <= CNT_W'(1);
                        sio_oe  <= 1'b1;
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (sck_fall) begin
                            if (bit_cnt == CNT_W'(WORD_W)) begin
                                frame_done <= 1'b1;
                                sio_q      <= 1'b0;
                                state      <= DONE;
                            end else begin
                                shreg   <= shreg << 1;
                                sio_q   <= shreg[WORD_W-2];
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        sio_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SIO_TRISTATE_EN
    assign SIO = sio_oe ? sio_q : 1'bz;
`else
    assign SIO = sio_q;
`endif

endmodule

// File: tb/tb_lm07_sensor_emulator.sv
// Directed bench for lm07_sensor_emulator: a bit-banged SPI master reads frames and checks each word.
module tb_lm07_sensor_emulator;

    logic        SYSCLK = 1'b0;
    logic        RSTN;
    logic        CS;
    logic        SCK;
    logic [15:0] temp_in;
    logic        temp_valid;
    wire         SIO;
    logic        sio_oe;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

`ifdef SIO_TRISTATE_EN
    localparam logic IDLE_SIO = 1'bz;
`else
    localparam logic IDLE_SIO = 1'b0;
`endif

    lm07_sensor_emulator dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .CS         (CS),
        .SCK        (SCK),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .SIO        (SIO),
        .sio_oe     (sio_oe),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    typedef struct {
        logic        pre_v;
        logic [15:0] pre_w;
        int          n;
        int          upd_at;
        logic [15:0] upd_w;
        logic [15:0] exp_word;
        int          exp_fd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic load_word(input logic [15:0] w);
        temp_in    = w;
        temp_valid = 1'b1;
        wait_cyc(1);
        temp_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_rx(input logic [15:0] word, input int n);
        logic [31:0] w;
        w = {16'h0000, word};
        if (n <= 16) return w >> (16 - n);
        return w << (n - 16);
    endfunction

    // One CS-low window of n SCK cycles; optional shadow update after SCK fall number upd_at.
    task automatic run_frame(input int n, input int upd_at, input logic [15:0] upd_w,
                             output logic [31:0] rx, output int fd);
        int start;
        start = fd_cnt;
        rx    = '0;
        CS    = 1'b0;
        wait_cyc(8);
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("oe_in_frame", 32'(sio_oe), 32'd1);
        for (int k = 1; k <= n; k++) begin
            rx  = {rx[30:0], SIO};
            SCK = 1'b1;
            wait_cyc(8);
            SCK = 1'b0;
            wait_cyc(8);
            if (k == upd_at) load_word(upd_w);
        end
        CS = 1'b1;
        wait_cyc(8);
        fd = fd_cnt - start;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_oe"}, 32'(sio_oe), 32'd0);
        chk({tag, "_sio"}, 32'(SIO), 32'(IDLE_SIO));
    endtask

    initial begin
        logic [31:0] rx;
        int          fd;

        vecs[0] = '{1'b0, 16'h0000, 16, 0, 16'h0000, 16'h0C80, 1};
        vecs[1] = '{1'b1, 16'h1938, 16, 0, 16'h0000, 16'h1938, 1};
        vecs[2] = '{1'b0, 16'h0000, 16, 0, 16'h0000, 16'h1938, 1};
        vecs[3] = '{1'b0, 16'h0000, 16, 5, 16'hFFF8, 16'h1938, 1};
        vecs[4] = '{1'b0, 16'h0000, 16, 0, 16'h0000, 16'hFFF8, 1};
        vecs[5] = '{1'b1, 16'hA5C3, 8,  0, 16'h0000, 16'hA5C3, 0};
        vecs[6] = '{1'b0, 16'h0000, 16, 0, 16'h0000, 16'hA5C3, 1};
        vecs[7] = '{1'b1, 16'h8001, 20, 0, 16'h0000, 16'h8001, 1};
        vecs[8] = '{1'b1, 16'h7FFF, 15, 0, 16'h0000, 16'h7FFF, 0};

        RSTN       = 1'b0;
        CS         = 1'b1;
        SCK        = 1'b0;
        temp_in    = '0;
        temp_valid = 1'b0;
        wait_cyc(3);
        chk_idle("reset");
        chk("reset_fd", 32'(frame_done), 32'd0);
        RSTN = 1'b1;
        wait_cyc(4);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_v) load_word(vecs[i].pre_w);
            run_frame(vecs[i].n, vecs[i].upd_at, vecs[i].upd_w, rx, fd);
            chk($sformatf("vec%0d_data", i), rx, exp_rx(vecs[i].exp_word, vecs[i].n));
            chk($sformatf("vec%0d_done", i), 32'(fd), 32'(vecs[i].exp_fd));
            chk_idle($sformatf("vec%0d_idle", i));
        end

        // Asynchronous reset in the middle of SHIFT.
        CS = 1'b0;
        wait_cyc(8);
        for (int k = 0; k < 6; k++) begin
            SCK = 1'b1;
            wait_cyc(8);
            SCK = 1'b0;
            wait_cyc(8);
        end
        RSTN = 1'b0;
        #1;
        chk_idle("midreset");
        CS  = 1'b1;
        SCK = 1'b0;
        wait_cyc(3);
        RSTN = 1'b1;
        wait_cyc(4);
        run_frame(16, 0, 16'h0000, rx, fd);
        chk("post_reset_data", rx, 32'h0000_0C80);
        chk("post_reset_done", 32'(fd), 32'd1);
        chk_idle("post_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm07_sensor_emulator.md
Name: lm07_sensor_emulator

Overview:
- RTL model of the LM07-style serial temperature sensor: the responder end of the read-only 3-wire SPI link (CS, SCK, SIO).
- Shifts a host-supplied temperature word out on SIO, MSB first, while an external master clocks SCK with CS low.
- Used on FPGA loopback builds and in benches so the sensor-read path can be exercised without the physical part.
- All logic runs on SYSCLK; CS and SCK are oversampled through synchronizers.

Parameters:
- WORD_W, 16, bits per frame shifted out on SIO.
- SYNC_STAGES, 2, synchronizer depth for CS and SCK (minimum 2).
- RESET_WORD, 16'h0C80, word presented before the first temp_valid (+25 C at 0.0625 C/LSB, left-justified by 3).

Ports:
- SYSCLK  input  1  system clock; must be at least 4x the SCK toggle rate.
- RSTN  input  1  asynchronous active-low reset.
- CS  input  1  chip select from master, active low, asynchronous to SYSCLK.
- SCK  input  1  serial clock from master; idles low while CS is high; master samples SIO on SCK rising.
- temp_in  input  WORD_W  next temperature word, already formatted by the host.
- temp_valid  input  1  one-SYSCLK strobe; captures temp_in into the shadow register.
- SIO  output  1  serial data to master.
- sio_oe  output  1  high while a frame is in progress (CS low, synchronized).
- frame_done  output  1  one-SYSCLK pulse when all WORD_W bits have been shifted.
- busy  output  1  high in LOAD, SHIFT and DONE states.

Behaviour:
- Reset (RSTN low, asynchronous):
  - shadow = RESET_WORD; shift register = 0; bit counter = 0; state = IDLE.
  - SIO = 0, sio_oe = 0, frame_done = 0, busy = 0.
  - Synchronizer flops reset to CS = 1, SCK = 0.
- Synchronization:
  - CS_s and SCK_s are the SYNC_STAGES-deep synchronized copies.
  - Edges are detected against a one-flop delayed copy: cs_fall, cs_rise, sck_fall.
  - SCK rising is not used.
  - Input-to-effect latency is SYNC_STAGES+1 SYSCLK cycles.
- Shadow register:
  - temp_valid loads temp_in on the next SYSCLK in any state.
  - Shift register contents are never touched by temp_valid; a mid-frame update takes effect on the next frame only.
- State machine:
  - IDLE: SIO = 0, sio_oe = 0. On cs_fall go to LOAD.
  - LOAD (1 cycle): shift register = shadow; SIO = shadow[WORD_W-1]; bit counter = 1; sio_oe = 1; go to SHIFT.
  - SHIFT: on each sck_fall, shift left by 1, SIO = new MSB, bit counter +1.
    - When an sck_fall occurs with bit counter == WORD_W, pulse frame_done, drive SIO = 0 and go to DONE.
  - DONE: SIO held 0; extra SCK edges are ignored. On cs_rise go to IDLE.
  - Any state other than IDLE: cs_rise forces IDLE next cycle, SIO = 0, sio_oe = 0, no frame_done (abort).
- Simultaneous events:
  - If cs_rise and sck_fall occur in the same cycle, the abort wins.
  - If temp_valid and LOAD occur in the same cycle, LOAD takes the old shadow; the new value applies next frame.
- Bit timing:
  - Bit k (k = 0 is MSB) is stable on SIO from the (k)th synchronized SCK fall (the CS fall for k = 0) until the next fall.
  - This guarantees setup before the master's rising sample, given the 4x clock ratio.
- Short frames (CS raised early, e.g. an 8-bit master read) are legal: they abort cleanly and the next frame restarts from the MSB.

Optional Feature:
- Macro: SIO_TRISTATE_EN.
- Defined: SIO is 1'bz whenever sio_oe = 0 (IDLE and reset), matching the real part's high-Z output.
- Undefined: SIO drives 0 when idle; sio_oe is still produced so an external pad can gate it.

Test Plan:
- Reset, no temp_valid, master reads 16 bits -> SIO sequence 0000_1100_1000_0000 (16'h0C80), frame_done pulses once, busy falls after CS rises.
- temp_valid with 16'h1938, then full read -> 16'h1938 shifted MSB first; next read without update returns 16'h1938 again.
- temp_valid with 16'hFFF8 asserted after the 5th SCK fall of a frame -> current frame still returns the old word; next frame returns 16'hFFF8.
- Master raises CS after 8 SCK cycles -> no frame_done, state IDLE, SIO = 0; next full frame returns all 16 bits starting from the MSB.
- 20 SCK cycles in one CS-low window -> bits 17-20 read as 0, exactly one frame_done.
- RSTN pulsed low mid-SHIFT -> SIO = 0 (or Z with SIO_TRISTATE_EN) immediately, shadow = 16'h0C80, next frame is clean.
